// File: rtl/alu_result_packer.sv
// Serialises each accepted ALU result into bytes for the TX FIFO write port,
// honouring FIFO back-pressure and counting results that arrive while busy.
module alu_result_packer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  OUT_VALID,
  input  logic                  FIFO_FULL,
  input  logic                  CLR_DROP,
  output logic [7:0]            WR_DATA,
  output logic                  WR_INC,
  output logic                  BUSY,
  output logic [7:0]            DROP_CNT
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned IdxW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {StIdle, StSend} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic       last_idx;
  logic       last_push;
  logic       acc;
  logic       drop;
  logic [7:0] sel_byte;

  // Pick byte idx of hold in the configured transmit order.
  always_comb begin
    sel_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx_q == IdxW'(k)) begin
        if (MSB_FIRST) sel_byte = hold_q[DATA_WIDTH-1-8*k -: 8];
        else           sel_byte = hold_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    BUSY    = (state_q == StSend);
    WR_INC  = BUSY & ~FIFO_FULL;
    WR_DATA = BUSY ? sel_byte : 8'h00;
  end

  assign last_idx  = (idx_q == IdxW'(NBYTES - 1));
  assign last_push = BUSY & WR_INC & last_idx;
  assign acc       = OUT_VALID & (~BUSY | last_push);
  assign drop      = OUT_VALID & ~acc;
  assign DROP_CNT  = drop_cnt_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    if (acc) begin
      // A new result on the last push edge continues straight into SEND.
      hold_d  = ALU_OUT;
      idx_d   = '0;
      state_d = StSend;
    end else if (WR_INC) begin
      if (last_idx) state_d = StIdle;
      else          idx_d   = idx_q + IdxW'(1);
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (CLR_DROP) begin
      drop_cnt_d = 8'h00;
    end else if (drop && (drop_cnt_q != 8'hff)) begin
      drop_cnt_d = drop_cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      idx_q      <= '0;
      drop_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_result_packer.sv
// Directed plus randomized bench for alu_result_packer (LSB- and MSB-first
// instances) checked against a byte-queue reference model.
module tb_alu_result_packer;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic        FIFO_FULL;
  logic        CLR_DROP;

  logic [7:0] wr_data_l, wr_data_m, drop_cnt_l, drop_cnt_m;
  logic       wr_inc_l, wr_inc_m, busy_l, busy_m;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes still owed to the FIFO for the current result.
  logic [7:0] q_l[$];
  logic [7:0] q_m[$];
  int         drops = 0;

  always #5 clk = ~clk;

  alu_result_packer #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .FIFO_FULL(FIFO_FULL), .CLR_DROP(CLR_DROP), .WR_DATA(wr_data_l),
    .WR_INC(wr_inc_l), .BUSY(busy_l), .DROP_CNT(drop_cnt_l)
  );

  alu_result_packer #(.DATA_WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .FIFO_FULL(FIFO_FULL), .CLR_DROP(CLR_DROP), .WR_DATA(wr_data_m),
    .WR_INC(wr_inc_m), .BUSY(busy_m), .DROP_CNT(drop_cnt_m)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic       b_l, b_m;
    logic [7:0] d_l, d_m;
    b_l = (q_l.size() != 0);
    b_m = (q_m.size() != 0);
    d_l = b_l ? q_l[0] : 8'h00;
    d_m = b_m ? q_m[0] : 8'h00;
    check("lsb_wr_inc", {7'd0, wr_inc_l}, {7'd0, b_l & ~FIFO_FULL});
    check("lsb_wr_data", wr_data_l, d_l);
    check("lsb_busy", {7'd0, busy_l}, {7'd0, b_l});
    check("lsb_drop_cnt", drop_cnt_l, 8'(drops));
    check("msb_wr_inc", {7'd0, wr_inc_m}, {7'd0, b_m & ~FIFO_FULL});
    check("msb_wr_data", wr_data_m, d_m);
    check("msb_busy", {7'd0, busy_m}, {7'd0, b_m});
    check("msb_drop_cnt", drop_cnt_m, 8'(drops));
  endtask

  task automatic model_edge(input logic v, input logic [15:0] d, input logic f, input logic c);
    if (q_l.size() != 0 && !f) begin
      void'(q_l.pop_front());
      void'(q_m.pop_front());
    end
    if (v && q_l.size() == 0) begin
      for (int k = 0; k < 2; k++) begin
        q_l.push_back(d[8*k +: 8]);
        q_m.push_back(d[15-8*k -: 8]);
      end
    end
    if (c) drops = 0;
    else if (v && q_l.size() != 0 && !(q_l.size() == 2 && q_l[0] == d[7:0] && 1'b0)) begin
      // Accepted results were just pushed; only a result that found the queue busy drops.
    end
  endtask

  task automatic model_reset();
    q_l.delete();
    q_m.delete();
    drops = 0;
  endtask

  // Drive one cycle: set inputs just after an edge, compare mid-cycle, advance the model.
  task automatic cycle(input logic v, input logic [15:0] d, input logic f, input logic c);
    bit was_free;
    OUT_VALID = v; ALU_OUT = d; FIFO_FULL = f; CLR_DROP = c;
    #4;
    compare_all();
    was_free = (q_l.size() == 0) || (q_l.size() == 1 && !f);
    @(posedge clk);
    model_edge(v, d, f, c);
    if (!c && v && !was_free && drops < 255) drops++;
    #1;
  endtask

  initial begin
    RST = 1'b0; ALU_OUT = 16'h0; OUT_VALID = 1'b0; FIFO_FULL = 1'b0; CLR_DROP = 1'b0;
    #2;
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    RST = 1'b1;

    // Basic LSB-first / MSB-first frame.
    cycle(1'b1, 16'hA5C3, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b0);

    // Back-pressure stall of three cycles.
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 16'hFFFF, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b0);

    // Back-to-back results without a bubble.
    cycle(1'b1, 16'h00FF, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b0);
    check("b2b_no_drop", drop_cnt_l, 8'h00);

    // Mid-frame drop leaves the frame untouched.
    cycle(1'b1, 16'h1111, 1'b0, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 16'h0, 1'b0, 1'b0);
    check("one_drop", drop_cnt_l, 8'h01);

    // Saturation: hold the frame with FIFO_FULL and drop 300 results.
    cycle(1'b1, 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
    check("saturated", drop_cnt_l, 8'hFF);
    cycle(1'b1, 16'h4444, 1'b1, 1'b1);
    check("clr_wins", drop_cnt_l, 8'h00);
    repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b0);

    // Asynchronous reset after the first byte of a frame.
    cycle(1'b1, 16'h5AA5, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    RST = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_wr_inc", {7'd0, wr_inc_l}, 8'h00);
    @(posedge clk);
    #1;
    compare_all();
    RST = 1'b1;
    cycle(1'b1, 16'h0102, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(2) == 0), 16'($urandom), ($urandom_range(3) == 0),
            ($urandom_range(40) == 0));
    end
    repeat (4) cycle(1'b0, 16'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_packer.md
# alu_result_packer

- Downstream stage of the ALU function units (arithmetic, logic, shift, compare).
- Captures each registered 16-bit result when its valid strobe is asserted.
- Splits the result into bytes and pushes them one per cycle into the TX FIFO write port, which feeds the UART transmitter.
- Honours FIFO back-pressure and counts results lost while a previous result is still being sent.

## Interface
Parameters:
- DATA_WIDTH, 16: result width; multiple of 8, range 8..32; NBYTES = DATA_WIDTH/8.
- MSB_FIRST, 0: 0 sends the least-significant byte first; 1 sends the most-significant byte first.

Ports:
- clk  in  1  system clock (ALU clock domain).
- RST  in  1  asynchronous, active-low reset.
- ALU_OUT  in  DATA_WIDTH  registered ALU result.
- OUT_VALID  in  1  one-cycle strobe; ALU_OUT is valid in the same cycle.
- FIFO_FULL  in  1  TX FIFO full; no push is allowed while high.
- CLR_DROP  in  1  synchronous clear of DROP_CNT.
- WR_DATA  out  8  byte presented to the FIFO.
- WR_INC  out  1  push strobe; the FIFO writes WR_DATA on each clk edge where WR_INC=1.
- BUSY  out  1  packer is holding an unsent or partially sent result.
- DROP_CNT  out  8  saturating count of discarded results.

## Operation
- State machine: IDLE, SEND.
- Registers:
  - shift/hold register `hold` (DATA_WIDTH).
  - byte index `idx` (0..NBYTES-1).
  - DROP_CNT.
- Accept condition: `acc = OUT_VALID & (state==IDLE | last_push)`.
  - `last_push = (state==SEND) & WR_INC & (idx==NBYTES-1)`.
- On acc, at the clock edge:
  - hold <= ALU_OUT.
  - idx <= 0.
  - state <= SEND.
- In SEND:
  - WR_INC = ~FIFO_FULL (combinational).
  - WR_DATA = byte idx of hold. Byte k is hold[8k+7:8k] when MSB_FIRST=0, and hold[DATA_WIDTH-1-8k -: 8] when MSB_FIRST=1.
  - On a push edge that is not the last byte: idx <= idx+1.
  - On a last_push edge with no acc: state <= IDLE.
  - On a last_push edge with acc: stay in SEND with the new result (back-to-back, no bubble).
- In IDLE: WR_INC=0 and WR_DATA=0.
- FIFO_FULL high in SEND:
  - WR_INC=0; hold, idx and state are frozen.
  - The stall is unbounded.
- Drops:
  - OUT_VALID with acc=0 discards that result.
  - DROP_CNT increments by 1, saturating at 255.
  - hold and the frame in progress are unaffected.
- CLR_DROP has priority: DROP_CNT <= 0 even if a drop occurs in the same cycle, and that drop is not counted.
- BUSY = (state==SEND), combinational from state.
- No width arithmetic beyond byte selection.
- ALU_OUT is ignored while OUT_VALID=0.

## Timing
- Reset values (RST low, asynchronous):
  - state=IDLE, hold=0, idx=0, DROP_CNT=0.
  - Outputs: WR_INC=0, WR_DATA=0x00, BUSY=0, DROP_CNT=0x00.
- Deassertion is synchronous to clk at the block level.
- Latency with OUT_VALID at edge E and FIFO not full:
  - byte 0 is pushed at edge E+1.
  - byte k is pushed at edge E+1+k.
  - BUSY is high from E to E+NBYTES.
- Throughput: one result per NBYTES cycles when FIFO_FULL stays low.
- Each FIFO_FULL cycle in SEND adds exactly one cycle of delay.
- WR_INC and WR_DATA are combinational from registered state and FIFO_FULL. The FIFO samples them on the same edge.
- RST asserted mid-frame:
  - returns immediately to IDLE and the remaining bytes are never pushed.
  - DROP_CNT clears.
  - An OUT_VALID in the first cycle after release is accepted normally.

## Test plan
- Basic LSB-first, DATA_WIDTH=16, MSB_FIRST=0: OUT_VALID with ALU_OUT=0xA5C3 at edge E -> WR_INC=1 with WR_DATA=0xC3 at E+1, then 0xA5 at E+2; BUSY=0 after E+2; DROP_CNT=0.
- Back-pressure: ALU_OUT=0x1234, FIFO_FULL=1 for cycles E+1..E+3 -> no WR_INC during the stall; 0x34 pushed at E+4, 0x12 at E+5.
- Back-to-back: second OUT_VALID (0xBEEF) in the cycle of the last push of 0x00FF -> byte stream 0xFF, 0x00, 0xEF, 0xBE on four consecutive edges; DROP_CNT=0.
- Drop and saturation:
  - OUT_VALID asserted in the cycle after acceptance, mid-frame -> DROP_CNT=1; the original frame is unchanged.
  - 300 drops -> DROP_CNT=255.
  - CLR_DROP together with a drop -> DROP_CNT=0.
- MSB_FIRST=1: ALU_OUT=0xA5C3 -> WR_DATA 0xA5 then 0xC3.
- Reset mid-frame: RST low after the first byte of 0x5AA5 is pushed -> WR_INC=0, BUSY=0, no second byte; new OUT_VALID 0x0102 after release -> 0x02, 0x01 pushed.
